// File: rtl/stats_latch_clr_ctrl.sv
// Interval-stats latch/clear sequencer: broadcasts a clear pulse, collects per-channel
// done pulses under a timeout, and serves latched stats rows through a registered read mux.
module stats_latch_clr_ctrl #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned NUM_ROWS      = 4,
  parameter int unsigned TIMEOUT_WIDTH = 6,
  parameter int unsigned RA_W          = $clog2(NUM_CH) + $clog2(NUM_ROWS)
) (
  input  logic                           iCLK_FC_CORE,
  input  logic                           iRST_FC_CORE,
  input  logic                           iINT_STATS_LATCH_CLR,
  output logic [NUM_CH-1:0]              oSTATS_LATCH_CLR,
  input  logic [NUM_CH-1:0]              iSTATS_CLR_DONE,
  input  logic                           iINT_STATS_BOTH_CH_DONE,
  output logic                           oSTATS_LATCH_CLR_DONE_LAT,
  output logic [NUM_CH-1:0]              oSTATS_TIMEOUT_MASK,
  output logic                           oSTATS_LATCH_OVERRUN,
  input  logic [NUM_CH*NUM_ROWS*128-1:0] iSTATS_DATA,
  input  logic [RA_W-1:0]                iINT_STATS_MEM_RA,
  output logic [127:0]                   oSTATS_MEM_DATA
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned ROW_W = $clog2(NUM_ROWS);

  typedef enum logic [1:0] {IDLE, CLR, WAIT, DONE} state_t;

  state_t                   state, stateNext;
  logic [NUM_CH-1:0]        doneMask, doneMaskNext, doneAll;
  logic [TIMEOUT_WIDTH-1:0] cnt, cntNext;
  logic [NUM_CH-1:0]        clrNext, tmNext;
  logic                     doneLatNext, overrunNext;

  logic [31:0]              chIdx, rowIdx, selIdx;
  logic [127:0]             rdSel, rdNext;
  logic                     chTimedOut, rdValid;

  assign doneAll = doneMask | iSTATS_CLR_DONE;

  always_comb begin
    stateNext    = state;
    doneMaskNext = doneMask;
    cntNext      = cnt;
    tmNext       = oSTATS_TIMEOUT_MASK;
    doneLatNext  = oSTATS_LATCH_CLR_DONE_LAT;
    clrNext      = '0;
    overrunNext  = iINT_STATS_LATCH_CLR && (state != IDLE);
    case (state)
      // Interval bookkeeping is cleared on acceptance so it already reads 0 during CLR.
      IDLE: if (iINT_STATS_LATCH_CLR) begin
        stateNext    = CLR;
        clrNext      = '1;
        doneMaskNext = '0;
        cntNext      = '0;
        tmNext       = '0;
      end
      CLR: stateNext = WAIT;
      WAIT: begin
        doneMaskNext = doneAll;
        cntNext      = cnt + TIMEOUT_WIDTH'(1);
        if (&doneAll) begin
          stateNext   = DONE;
          doneLatNext = 1'b1;
        end else if (&cnt) begin
          stateNext   = DONE;
          doneLatNext = 1'b1;
          tmNext      = ~doneAll;
        end
      end
      DONE: if (iINT_STATS_BOTH_CH_DONE) begin
        stateNext   = IDLE;
        doneLatNext = 1'b0;
      end
      default: stateNext = IDLE;
    endcase
  end

  generate
    if (CH_W > 0) begin : gChField
      assign chIdx = 32'(iINT_STATS_MEM_RA[RA_W-1 -: CH_W]);
    end else begin : gNoChField
      assign chIdx = '0;
    end
  endgenerate

  assign rowIdx     = 32'(iINT_STATS_MEM_RA[ROW_W-1:0]);
  assign selIdx     = chIdx * NUM_ROWS + rowIdx;
  assign rdSel      = 128'(iSTATS_DATA >> (selIdx * 32'd128));
  assign chTimedOut = 1'(oSTATS_TIMEOUT_MASK >> chIdx);
  assign rdValid    = (chIdx < NUM_CH) && !chTimedOut;
  assign rdNext     = rdValid ? rdSel : '0;

  always_ff @(posedge iCLK_FC_CORE) begin
    if (iRST_FC_CORE) begin
      state                     <= IDLE;
      doneMask                  <= '0;
      cnt                       <= '0;
      oSTATS_LATCH_CLR          <= '0;
      oSTATS_LATCH_CLR_DONE_LAT <= 1'b0;
      oSTATS_TIMEOUT_MASK       <= '0;
      oSTATS_LATCH_OVERRUN      <= 1'b0;
      oSTATS_MEM_DATA           <= '0;
    end else begin
      state                     <= stateNext;
      doneMask                  <= doneMaskNext;
      cnt                       <= cntNext;
      oSTATS_LATCH_CLR          <= clrNext;
      oSTATS_LATCH_CLR_DONE_LAT <= doneLatNext;
      oSTATS_TIMEOUT_MASK       <= tmNext;
      oSTATS_LATCH_OVERRUN      <= overrunNext;
      oSTATS_MEM_DATA           <= rdNext;
    end
  end

endmodule

// File: tb/tb_stats_latch_clr_ctrl.sv
// Directed bench for stats_latch_clr_ctrl: interval-level reference model checked every
// cycle, plus hand-computed expectations at key cycles and a read-mux sweep on a 3-channel build.
module tb_stats_latch_clr_ctrl;

  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          rst, req, ack;
  logic [1:0]    done;
  logic [1023:0] data2;
  logic [2:0]    ra;
  logic [1:0]    clr, tmask;
  logic          doneLat, ovr;
  logic [127:0]  rd;

  logic [1535:0] data3;
  logic [3:0]    ra3;
  logic [2:0]    clr3, tm3;
  logic          dl3, ov3;
  logic [127:0]  rd3;
  logic [2:0]    zero3 = '0;
  logic          zero1 = 1'b0;

  int nChecks = 0;
  int nErrors = 0;
  logic checkOn = 1'b0;

  always #5 clk = ~clk;

  stats_latch_clr_ctrl #(.NUM_CH(2), .NUM_ROWS(4), .TIMEOUT_WIDTH(TW)) u_dut (
    .iCLK_FC_CORE(clk), .iRST_FC_CORE(rst), .iINT_STATS_LATCH_CLR(req),
    .oSTATS_LATCH_CLR(clr), .iSTATS_CLR_DONE(done), .iINT_STATS_BOTH_CH_DONE(ack),
    .oSTATS_LATCH_CLR_DONE_LAT(doneLat), .oSTATS_TIMEOUT_MASK(tmask),
    .oSTATS_LATCH_OVERRUN(ovr), .iSTATS_DATA(data2), .iINT_STATS_MEM_RA(ra),
    .oSTATS_MEM_DATA(rd));

  stats_latch_clr_ctrl #(.NUM_CH(3), .NUM_ROWS(4), .TIMEOUT_WIDTH(TW)) u_dut3 (
    .iCLK_FC_CORE(clk), .iRST_FC_CORE(rst), .iINT_STATS_LATCH_CLR(zero1),
    .oSTATS_LATCH_CLR(clr3), .iSTATS_CLR_DONE(zero3), .iINT_STATS_BOTH_CH_DONE(zero1),
    .oSTATS_LATCH_CLR_DONE_LAT(dl3), .oSTATS_TIMEOUT_MASK(tm3),
    .oSTATS_LATCH_OVERRUN(ov3), .iSTATS_DATA(data3), .iINT_STATS_MEM_RA(ra3),
    .oSTATS_MEM_DATA(rd3));

  function automatic logic [127:0] rowVal(int c, int r);
    return {32'hDEAD0000 + 32'(c * 256 + r), 32'h0F0F0000 ^ 32'(c * 16 + r + 1),
            32'hCAFEBABE, 32'(c * 4 + r + 1)};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks an interval as "age since accepted request" and the set of
  // channels heard from; completion is all channels heard or 2^TW collection cycles elapsed.
  logic         mActive = 1'b0, mComplete = 1'b0;
  int           mAge = 0;
  logic [1:0]   mGot = '0;
  logic [1:0]   eClr = '0, eMask = '0;
  logic         eDoneLat = 1'b0, eOvr = 1'b0;
  logic [127:0] eRd = '0;

  always @(posedge clk) begin : model
    logic act, cmp;
    int age;
    logic [1:0] got, msk, nClr;
    logic nOvr;
    logic [127:0] nRd;
    act = mActive; cmp = mComplete; age = mAge; got = mGot; msk = eMask;
    if (rst) begin
      act = 1'b0; cmp = 1'b0; age = 0; got = '0; msk = '0;
      nClr = '0; nOvr = 1'b0; nRd = '0;
    end else begin
      nRd  = msk[ra[2]] ? 128'h0 : rowVal(int'(ra[2]), int'(ra[1:0]));
      nOvr = req && (act || cmp);
      nClr = '0;
      if (!act && !cmp) begin
        if (req) begin
          act = 1'b1; age = 0; got = '0; msk = '0; nClr = 2'b11;
        end
      end else if (act) begin
        age++;
        if (age >= 2) begin
          got = got | done;
          if (got == 2'b11) begin
            act = 1'b0; cmp = 1'b1;
          end else if (age - 2 == (1 << TW) - 1) begin
            act = 1'b0; cmp = 1'b1; msk = ~got;
          end
        end
      end else if (ack) begin
        cmp = 1'b0;
      end
    end
    mActive <= act; mComplete <= cmp; mAge <= age; mGot <= got;
    eMask <= msk; eClr <= nClr; eOvr <= nOvr; eRd <= nRd; eDoneLat <= cmp;
  end

  always @(negedge clk) begin
    if (checkOn) begin
      chk("clr", 128'(clr), 128'(eClr));
      chk("doneLat", 128'(doneLat), 128'(eDoneLat));
      chk("tmask", 128'(tmask), 128'(eMask));
      chk("overrun", 128'(ovr), 128'(eOvr));
      chk("rdata", rd, eRd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] prev3, exp3;
    rst = 1'b1; req = 1'b0; ack = 1'b0; done = '0; ra = '0; ra3 = '0;
    data2 = '0; data3 = '0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 4; r++) begin
        data3[(c * 4 + r) * 128 +: 128] = rowVal(c, r);
        if (c < 2) data2[(c * 4 + r) * 128 +: 128] = rowVal(c, r);
      end

    tick();
    checkOn = 1'b1;
    tick();
    chk("rst_clr", 128'(clr), 128'h0);
    chk("rst_doneLat", 128'(doneLat), 128'h0);
    chk("rst_tmask", 128'(tmask), 128'h0);
    chk("rst_ovr", 128'(ovr), 128'h0);
    chk("rst_rdata", rd, 128'h0);
    rst = 1'b0; ra = 3'b001;
    tick(); tick();
    chk("idle_rd_ch0r1", rd, rowVal(0, 1));

    // Both channels respond immediately
    req = 1'b1; tick();
    req = 1'b0;
    chk("t1_clr_pulse", 128'(clr), 128'h3);
    tick();
    chk("t2_clr_off", 128'(clr), 128'h0);
    done = 2'b11; tick();
    done = 2'b00;
    chk("t3_doneLat", 128'(doneLat), 128'h1);
    chk("t3_tmask", 128'(tmask), 128'h0);
    tick(); tick(); tick();
    ack = 1'b1; tick();
    ack = 1'b0;
    chk("t7_doneLat_drop", 128'(doneLat), 128'h0);

    // Channel 1 never answers: timeout after 2^TW collection cycles
    ra = 3'b110; req = 1'b1; tick();
    req = 1'b0; tick();
    tick();
    done = 2'b01; tick();
    done = 2'b00;
    repeat (61) tick();
    chk("to_t65_doneLat", 128'(doneLat), 128'h0);
    tick();
    chk("to_t66_doneLat", 128'(doneLat), 128'h1);
    chk("to_t66_tmask", 128'(tmask), 128'h2);
    tick();
    chk("to_rd_ch1_zero", rd, 128'h0);
    ra = 3'b010; tick();
    chk("to_rd_ch0r2", rd, rowVal(0, 2));
    ack = 1'b1; tick();
    ack = 1'b0;
    chk("to_mask_hold", 128'(tmask), 128'h2);

    // Last done lands on the terminal count; a done pulse in CLR is ignored
    ra = 3'b101; req = 1'b1; tick();
    req = 1'b0;
    chk("tc_clr_mask0", 128'(tmask), 128'h0);
    done = 2'b10; tick();
    done = 2'b01; tick();
    done = 2'b00;
    repeat (62) tick();
    chk("tc_t65_doneLat", 128'(doneLat), 128'h0);
    done = 2'b10; tick();
    done = 2'b00;
    chk("tc_doneLat", 128'(doneLat), 128'h1);
    chk("tc_tmask", 128'(tmask), 128'h0);
    tick();
    chk("tc_rd_ch1r1", rd, rowVal(1, 1));
    ack = 1'b1; tick();
    ack = 1'b0;

    // Overrun in WAIT, in DONE, and together with the releasing ack
    req = 1'b1; tick();
    req = 1'b0; tick();
    tick();
    req = 1'b1; tick();
    req = 1'b0;
    chk("ov_wait_pulse", 128'(ovr), 128'h1);
    chk("ov_wait_noclr", 128'(clr), 128'h0);
    done = 2'b11; tick();
    done = 2'b00; tick();
    chk("ov_done_entry", 128'(doneLat), 128'h1);
    req = 1'b1; tick();
    req = 1'b0;
    chk("ov_done_pulse", 128'(ovr), 128'h1);
    tick();
    chk("ov_pulse_end", 128'(ovr), 128'h0);
    req = 1'b1; ack = 1'b1; tick();
    req = 1'b0; ack = 1'b0;
    chk("ov_ack_pulse", 128'(ovr), 128'h1);
    chk("ov_ack_noclr", 128'(clr), 128'h0);
    chk("ov_ack_release", 128'(doneLat), 128'h0);
    tick();
    chk("ov_ack_stays_idle", 128'(clr), 128'h0);

    // Reset in the middle of WAIT with stale done pulses
    ra = 3'b000; req = 1'b1; tick();
    req = 1'b0; tick();
    done = 2'b01; tick();
    done = 2'b00; tick();
    rst = 1'b1; done = 2'b11; tick();
    chk("mr_clr", 128'(clr), 128'h0);
    chk("mr_doneLat", 128'(doneLat), 128'h0);
    chk("mr_tmask", 128'(tmask), 128'h0);
    chk("mr_rdata", rd, 128'h0);
    tick();
    rst = 1'b0; done = 2'b00; tick();
    req = 1'b1; tick();
    req = 1'b0;
    chk("mr_new_clr", 128'(clr), 128'h3);
    tick();
    done = 2'b01; tick();
    done = 2'b00; tick();
    done = 2'b10;
    chk("mr_partial_wait", 128'(doneLat), 128'h0);
    tick();
    done = 2'b00;
    chk("mr_done", 128'(doneLat), 128'h1);
    chk("mr_tmask_done", 128'(tmask), 128'h0);
    ack = 1'b1; tick();
    ack = 1'b0; tick();

    // Read-mux sweep on the 3-channel build, including the unpopulated channel 3
    prev3 = rd3;
    for (int a = 0; a < 16; a++) begin
      ra3 = 4'(a);
      #1;
      chk("rd3_latency_hold", rd3, prev3);
      tick();
      exp3 = ((a >> 2) < 3) ? rowVal(a >> 2, a & 3) : 128'h0;
      chk("rd3_sweep", rd3, exp3);
      chk("rd3_ctrl_idle", 128'({clr3, dl3, tm3, ov3}), 128'h0);
      prev3 = exp3;
    end

    checkOn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
